// File: rtl/instr_queue.sv
// Fetch-side instruction queue. Accepts one fetch group per cycle, drops the
// slots younger than the first predicted-taken one, packs the survivors into
// a circular FIFO and hands one instruction per cycle to decode.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. On the fetch side valid_i/ready_o move a whole group, and ready_o
// depends only on registered state and flush_i. On the decode side valid_o/ready_i
// move the head entry, and valid_o depends only on registered state and flush_i.

package tortoise_pkg;
   localparam int unsigned INSTR_PER_FETCH = 2;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef struct packed {
      logic  is_taken;
      addr_t predict_address;
   } sbe_predict_t;
endpackage

module instr_queue #(
   parameter int unsigned NR_INSTRS = tortoise_pkg::INSTR_PER_FETCH,
   parameter int unsigned DEPTH     = 8
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        flush_i,
   input  logic                                        valid_i,
   output logic                                        ready_o,
   input  logic                 [NR_INSTRS-1:0]        instr_valid_i,
   input  tortoise_pkg::addr_t  [NR_INSTRS-1:0]        branch_pc_i,
   input  tortoise_pkg::instr_t [NR_INSTRS-1:0]        instr_i,
   input  tortoise_pkg::sbe_predict_t [NR_INSTRS-1:0]  sbe_predict_i,
   output logic                                        valid_o,
   input  logic                                        ready_i,
   output tortoise_pkg::addr_t                         pc_o,
   output tortoise_pkg::instr_t                        instr_o,
   output tortoise_pkg::sbe_predict_t                  sbe_predict_o,
   output logic                 [$clog2(DEPTH):0]      count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   // A group is accepted only while this many or fewer entries are occupied.
   localparam logic [CNT_W-1:0] GROUP_ROOM = CNT_W'(DEPTH - NR_INSTRS);

   typedef struct packed {
      tortoise_pkg::addr_t        pc;
      tortoise_pkg::instr_t       instr;
      tortoise_pkg::sbe_predict_t pred;
   } entry_t;

   entry_t               mem_q [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q,  count_d;

   logic [NR_INSTRS-1:0] keep;
   logic [PTR_W-1:0]     slot_off [NR_INSTRS];
   logic [CNT_W-1:0]     kept_cnt;
   logic                 taken_seen;
   logic                 push;
   logic                 fire;

   // Select surviving slots: a slot survives if it is valid and no older valid
   // slot predicted taken; each survivor gets its packed offset from wr_ptr.
   always_comb begin
      keep       = '0;
      kept_cnt   = '0;
      taken_seen = 1'b0;
      for (int i = 0; i < NR_INSTRS; i++) begin
         slot_off[i] = PTR_W'(kept_cnt);
         if (instr_valid_i[i] && !taken_seen) begin
            keep[i]  = 1'b1;
            kept_cnt = kept_cnt + CNT_W'(1);
         end
         if (instr_valid_i[i] && sbe_predict_i[i].is_taken) begin
            taken_seen = 1'b1;
         end
      end
   end

   assign ready_o = !flush_i && (count_q <= GROUP_ROOM);
   assign valid_o = (count_q != '0) && !flush_i;
   assign push    = valid_i && ready_o;
   assign fire    = valid_o && ready_i;

   // Pointer and occupancy next state; flush rewinds everything to empty.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(fire);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(kept_cnt);
         end
         count_d = count_q + (push ? kept_cnt : '0) - CNT_W'(fire);
      end
   end

   // State registers and storage writes; reset also clears storage so the
   // data outputs read zero afterwards.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            for (int i = 0; i < NR_INSTRS; i++) begin
               if (keep[i]) begin
                  mem_q[wr_ptr_q + slot_off[i]] <= '{pc:    branch_pc_i[i],
                                                     instr: instr_i[i],
                                                     pred:  sbe_predict_i[i]};
               end
            end
         end
      end
   end

   assign pc_o          = mem_q[rd_ptr_q].pc;
   assign instr_o       = mem_q[rd_ptr_q].instr;
   assign sbe_predict_o = mem_q[rd_ptr_q].pred;
   assign count_o       = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue with NR_INSTRS=2, DEPTH=8: directed scenarios with
// constant expectations plus a randomized run against a queue-based model.
module tb_instr_queue;
   localparam int NR    = 2;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   logic                 flush_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [NR-1:0]        instr_valid_i;
   logic [NR-1:0][31:0]  branch_pc_i;
   logic [NR-1:0][31:0]  instr_i;
   logic [NR-1:0][32:0]  sbe_predict_i;
   logic                 valid_o;
   logic                 ready_i;
   logic [31:0]          pc_o;
   logic [31:0]          instr_o;
   logic [32:0]          sbe_predict_o;
   logic [3:0]           count_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Model contents: {pc, instr, prediction} per queued instruction.
   logic [96:0] exp_q[$];

   always #5 clk = ~clk;

   instr_queue #(.NR_INSTRS(NR), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
      .ready_o(ready_o), .instr_valid_i(instr_valid_i), .branch_pc_i(branch_pc_i),
      .instr_i(instr_i), .sbe_predict_i(sbe_predict_i), .valid_o(valid_o),
      .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o),
      .sbe_predict_o(sbe_predict_o), .count_o(count_o)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      flush_i       = 1'b0;
      valid_i       = 1'b0;
      ready_i       = 1'b0;
      instr_valid_i = '0;
      branch_pc_i   = '0;
      instr_i       = '0;
      sbe_predict_i = '0;
   endtask

   task automatic drive_group(input logic v, input logic [1:0] mask,
                              input logic [31:0] pc0, input logic [31:0] pc1,
                              input logic t0, input logic t1, input logic rdy);
      valid_i          = v;
      ready_i          = rdy;
      instr_valid_i    = mask;
      branch_pc_i[0]   = pc0;
      branch_pc_i[1]   = pc1;
      instr_i[0]       = ~pc0;
      instr_i[1]       = ~pc1;
      sbe_predict_i[0] = {t0, pc0 + 32'h40};
      sbe_predict_i[1] = {t1, pc1 + 32'h40};
   endtask

   // Reference model: flush/reset empty the queue; otherwise pop the head on
   // a decode transfer and append the surviving slots of an accepted group.
   task automatic model_commit();
      int   sz;
      logic acc, fr, taken;
      if (!rst_ni || flush_i) begin
         exp_q.delete();
      end else begin
         sz  = exp_q.size();
         acc = valid_i && ((DEPTH - sz) >= NR);
         fr  = (sz != 0) && ready_i;
         if (fr) void'(exp_q.pop_front());
         if (acc) begin
            taken = 1'b0;
            for (int i = 0; i < NR; i++) begin
               if (instr_valid_i[i] && !taken)
                  exp_q.push_back({branch_pc_i[i], instr_i[i], sbe_predict_i[i]});
               if (instr_valid_i[i] && sbe_predict_i[i][32]) taken = 1'b1;
            end
         end
      end
   endtask

   // One clock: commit the model at the edge, return at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_flush();
      drive_idle();
      flush_i = 1'b1;
      tick();
      drive_idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      rst_ni = 1'b0;
      tick();
      tick();
      #1;
      n_tests++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 4'd0 || pc_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hold: valid=%b ready=%b count=%0d pc=%h, want 0 1 0 0",
                  valid_o, ready_o, count_o, pc_o);
      end
      rst_ni = 1'b1;
      #1;
      n_tests++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 4'd0 || pc_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_release: valid=%b ready=%b count=%0d pc=%h, want 0 1 0 0",
                  valid_o, ready_o, count_o, pc_o);
      end
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] want_pc [2];
      want_pc[0] = 32'h8000_0000;
      want_pc[1] = 32'h8000_0004;
      do_flush();
      drive_group(1'b1, 2'b11, want_pc[0], want_pc[1], 1'b0, 1'b0, 1'b1);
      #1;
      n_tests++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_accept: ready=%b valid=%b, want 1 0", ready_o, valid_o);
      end
      tick();
      valid_i = 1'b0;
      for (int n = 0; n < 2; n++) begin
         #1;
         n_tests++;
         if (valid_o !== 1'b1 || pc_o !== want_pc[n] || instr_o !== ~want_pc[n] ||
             count_o !== 4'(2 - n)) begin
            n_fail++;
            $display("FAIL basic_out%0d: valid=%b pc=%h instr=%h count=%0d, want 1 %h %h %0d",
                     n, valid_o, pc_o, instr_o, count_o, want_pc[n], ~want_pc[n], 2 - n);
         end
         tick();
      end
      #1;
      n_tests++;
      if (valid_o !== 1'b0 || count_o !== 4'd0) begin
         n_fail++;
         $display("FAIL basic_empty: valid=%b count=%0d, want 0 0", valid_o, count_o);
      end
   endtask

   task automatic test_taken();
      // slot0 taken: slot1 dropped
      do_flush();
      drive_group(1'b1, 2'b11, 32'h8000_0000, 32'h8000_0004, 1'b1, 1'b0, 1'b0);
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd1 || pc_o !== 32'h8000_0000 || sbe_predict_o !== {1'b1, 32'h8000_0040}) begin
         n_fail++;
         $display("FAIL taken_slot0: count=%0d pc=%h pred=%h, want 1 80000000 %h",
                  count_o, pc_o, sbe_predict_o, {1'b1, 32'h8000_0040});
      end
      // misaligned group, slot1 taken
      do_flush();
      drive_group(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0004, 1'b0, 1'b1, 1'b0);
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd1 || pc_o !== 32'h8000_0004) begin
         n_fail++;
         $display("FAIL taken_mask10: count=%0d pc=%h, want 1 80000004", count_o, pc_o);
      end
      // invalid slot0 marked taken must not drop slot1
      do_flush();
      drive_group(1'b1, 2'b10, 32'h9000_0000, 32'h9000_0004, 1'b1, 1'b0, 1'b0);
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd1 || pc_o !== 32'h9000_0004) begin
         n_fail++;
         $display("FAIL taken_invalid_slot: count=%0d pc=%h, want 1 90000004", count_o, pc_o);
      end
      // empty mask: accepted with no state change
      do_flush();
      drive_group(1'b1, 2'b00, 32'h9100_0000, 32'h9100_0004, 1'b0, 1'b0, 1'b0);
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_mask: count=%0d valid=%b ready=%b, want 0 0 1",
                  count_o, valid_o, ready_o);
      end
   endtask

   task automatic test_fill(input int width);
      int cnt;
      do_flush();
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         drive_group(1'b1, (width == 2) ? 2'b11 : 2'b01, 32'h4000 + 8 * n,
                     32'h4004 + 8 * n, 1'b0, 1'b0, 1'b0);
         #1;
         n_tests++;
         if (ready_o !== (cnt <= 6) || count_o !== 4'(cnt) || count_o > 4'd8) begin
            n_fail++;
            $display("FAIL fill_w%0d_step%0d: ready=%b count=%0d, want %b %0d",
                     width, n, ready_o, count_o, (cnt <= 6), cnt);
         end
         tick();
         if (cnt <= 6) cnt += width;
      end
      drive_idle();
   endtask

   task automatic test_back_to_back();
      do_flush();
      for (int g = 0; g < 3; g++) begin
         drive_group(1'b1, 2'b11, 32'h1000 + 8 * g, 32'h1004 + 8 * g, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive_group(1'b1, 2'b11, 32'h1018, 32'h101c, 1'b0, 1'b0, 1'b1);
      #1;
      n_tests++;
      if (count_o !== 4'd6 || ready_o !== 1'b1 || valid_o !== 1'b1 || pc_o !== 32'h1000) begin
         n_fail++;
         $display("FAIL b2b_pre: count=%0d ready=%b valid=%b pc=%h, want 6 1 1 00001000",
                  count_o, ready_o, valid_o, pc_o);
      end
      tick();
      drive_idle();
      ready_i = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         #1;
         n_tests++;
         if (valid_o !== 1'b1 || pc_o !== 32'(32'h1000 + 4 * n) || count_o !== 4'(8 - n)) begin
            n_fail++;
            $display("FAIL b2b_drain%0d: valid=%b pc=%h count=%0d, want 1 %h %0d",
                     n, valid_o, pc_o, count_o, 32'(32'h1000 + 4 * n), 8 - n);
         end
         tick();
      end
      #1;
      n_tests++;
      if (valid_o !== 1'b0 || count_o !== 4'd0) begin
         n_fail++;
         $display("FAIL b2b_empty: valid=%b count=%0d, want 0 0", valid_o, count_o);
      end
   endtask

   task automatic test_flush();
      do_flush();
      drive_group(1'b1, 2'b11, 32'h3000, 32'h3004, 1'b0, 1'b0, 1'b0);
      tick();
      drive_group(1'b1, 2'b11, 32'h3008, 32'h300c, 1'b0, 1'b0, 1'b0);
      tick();
      drive_group(1'b1, 2'b01, 32'h3010, 32'h3014, 1'b0, 1'b0, 1'b0);
      tick();
      drive_group(1'b1, 2'b11, 32'hdead_0000, 32'hdead_0004, 1'b0, 1'b0, 1'b1);
      flush_i = 1'b1;
      #1;
      n_tests++;
      if (count_o !== 4'd5 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cycle: count=%0d valid=%b ready=%b, want 5 0 0",
                  count_o, valid_o, ready_o);
      end
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_after: count=%0d valid=%b ready=%b, want 0 0 1",
                  count_o, valid_o, ready_o);
      end
      drive_group(1'b1, 2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0);
      tick();
      drive_idle();
      #1;
      n_tests++;
      if (count_o !== 4'd2 || pc_o !== 32'h2000) begin
         n_fail++;
         $display("FAIL flush_newgroup: count=%0d pc=%h, want 2 00002000", count_o, pc_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] base;
      logic        exp_valid, exp_ready;
      int          sz;
      do_flush();
      base = 32'h0010_0000;
      for (int c = 0; c < 1000; c++) begin
         drive_group($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), base, base + 4,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 2) != 0);
         flush_i = ($urandom_range(0, 99) == 0);
         rst_ni  = ($urandom_range(0, 299) != 0);
         base    = base + 8;
         #1;
         sz        = exp_q.size();
         exp_valid = (sz != 0) && !flush_i;
         exp_ready = !flush_i && ((DEPTH - sz) >= NR);
         n_tests++;
         if (valid_o !== exp_valid || ready_o !== exp_ready || count_o !== 4'(sz)) begin
            n_fail++;
            $display("FAIL rand_ctrl c%0d: valid=%b ready=%b count=%0d, want %b %b %0d",
                     c, valid_o, ready_o, count_o, exp_valid, exp_ready, sz);
         end
         if (exp_valid) begin
            n_tests++;
            if ({pc_o, instr_o, sbe_predict_o} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL rand_head c%0d: pc=%h instr=%h pred=%h, want %h",
                        c, pc_o, instr_o, sbe_predict_o, exp_q[0]);
            end
         end
         tick();
      end
      rst_ni = 1'b1;
      drive_idle();
   endtask

   initial begin
      rst_ni = 1'b0;
      drive_idle();
      @(negedge clk);
      test_reset();
      test_basic();
      test_taken();
      test_fill(2);
      test_fill(1);
      test_back_to_back();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
